alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have dispatch inputs:
- ALUen  in  1  dispatch valid.
- ALUop  in  `OpBus  opcode.
- ALUoperandO  in  32  operand 1 value.
- ALUoperandT  in  32  operand 2 value.
- ALUtagO  in  `TagBus  operand 1 producer tag.
- ALUtagT  in  `TagBus  operand 2 producer tag.
- ALUtagW  in  `TagBus  destination tag.
- ALUnameW  in  5  destination register.
- ALUaddr  in  32  instruction address.
REQ-004 SHALL have CDB snoop inputs:
- ALUcdbEn  in  1, ALUcdbTag  in  `TagBus, ALUcdbData  in  32: ALU broadcast.
- LScdbEn  in  1, LScdbTag  in  `TagBus, LScdbData  in  32: LS buffer broadcast.
REQ-005 SHALL have: ALUfreeStatus  out  `rsSize (16)  bit i=1 means entry i is allocatable.
REQ-006 SHALL have issue outputs:
- EXen  out  1  issue valid.
- EXop  out  `OpBus.
- EXoperandO  out  32.
- EXoperandT  out  32.
- EXtagW  out  `TagBus.
- EXnameW  out  5.
- EXaddr  out  32.
REQ-007 Tags SHALL be 6 bits: {1'b0, prefix, root[3:0]}, with ALU prefix 0 and LS prefix 1; tagFree = 6'b100000 means the operand is ready.

Function
REQ-008 SHALL hold 16 entries, each with valid, op, two values, two tags, tagW, nameW and addr.
REQ-009 When ALUen=1, the entry indexed by ALUtagW[3:0] SHALL be written at the next edge and valid set.
REQ-010 ALUen=1 targeting an entry that is already valid SHALL be ignored; the entry is left unchanged.
REQ-011 Each cycle, any valid entry whose tagO/tagT equals an asserted CDB tag SHALL capture that CDB data and set the tag to tagFree.
REQ-012 CDB tags equal to tagFree SHALL be ignored.
REQ-013 When a dispatch operand tag matches an active CDB tag in the same cycle, the entry SHALL store the CDB data with tagFree (no lost wakeup).
REQ-014 If both CDBs carry the same tag, the ALU CDB SHALL take priority.
REQ-015 An entry SHALL be ready when it is valid and both of its tags are tagFree.
REQ-016 Each cycle, the lowest-index ready entry SHALL be selected; its fields SHALL be registered onto EX* at the next edge with EXen=1, and its valid bit cleared at that edge.
REQ-017 At most one issue per cycle; when no entry is ready, EXen=0 and the other EX* outputs hold their last values.
REQ-018 Readiness SHALL be evaluated on registered state, so:
- an entry dispatched at edge E issues no earlier than edge E+1;
- an entry woken by a CDB broadcast in the cycle ending at edge E issues no earlier than edge E+1.
REQ-019 ALUfreeStatus SHALL be combinational: ~valid, with bit ALUtagW[3:0] also cleared while ALUen=1, so an in-flight dispatch is never reallocated.
REQ-020 A freed entry SHALL reappear in ALUfreeStatus in the cycle after its issue edge.
REQ-021 Issue and dispatch to different entries in the same cycle SHALL both take effect.

Reset
REQ-022 While rst=0, all valid bits, EXen, ALUfreeStatus-backing state and EX* data SHALL be 0, and EXtagW SHALL be tagFree, asynchronously.
REQ-023 Reset asserted mid-operation SHALL discard all entries; ALUfreeStatus reads 16'hFFFF.
REQ-024 Outputs SHALL resume on the first edge after rst rises.

Structure
REQ-025 `TagBus`, `OpBus`, `rsSize`, tagFree and the prefixes SHALL live in the shared defines package.
REQ-026 The lowest-ready-index priority encoder SHALL be a sub-module named rs_pick, reusable by the LS buffer.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Dispatch tagW=6'h03, tagO=tagT=tagFree, values 5/7 -> EXen=1 with EXoperandO=5, EXoperandT=7 one edge later; ALUfreeStatus[3] returns to 1 in the following cycle.
- Dispatch tagO=6'h12 (LS entry 2) -> no issue; LScdbEn with LScdbTag=6'h12, data 32'hDEAD -> issue on the next edge with EXoperandO=32'hDEAD.
- Dispatch tagT=6'h05 in the same cycle as ALUcdbTag=6'h05, data 9 -> the entry captures 9 and issues on the next edge.
- Entries 1 and 6 both ready -> entry 1 issues first, entry 6 one cycle later.
- ALUen=1 with tagW=6'h04 -> ALUfreeStatus[4]=0 in that same cycle; a second dispatch to entry 4 while it is valid is ignored.
- Assert rst=0 with 3 entries valid -> EXen=0 immediately and ALUfreeStatus=16'hFFFF.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared ALU/LS reservation-station definitions: bus widths, tag encoding,
// entry layout and the common-data-bus snoop helper.
package alu_rs_pkg;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 6;   // TagBus
    localparam int OP_W    = 4;   // OpBus
    localparam int NAME_W  = 5;
    localparam int RS_SIZE = 16;  // rsSize
    localparam int IDX_W   = 4;

    // Tag layout is {1'b0, prefix, root[3:0]}; bit 5 alone marks "no producer".
    localparam logic [TAG_W-1:0] TAG_FREE   = 6'b100000;
    localparam logic             PREFIX_ALU = 1'b0;
    localparam logic             PREFIX_LS  = 1'b1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [OP_W-1:0]  op_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] val;
        tag_t                     tag;
    } operand_t;

    typedef struct packed {
        op_t               op;
        operand_t          opo;
        operand_t          opt;
        tag_t              tagw;
        logic [NAME_W-1:0] namew;
        logic [DATA_W-1:0] addr;
    } entry_t;

    // Resolve one operand against both broadcast buses. An operand that is
    // already free never matches, so a CDB tag of TAG_FREE is inert. The ALU
    // bus is checked first and therefore wins a same-tag collision.
    function automatic operand_t snoop(
        input operand_t          cur,
        input logic              alu_en,
        input tag_t              alu_tag,
        input logic [DATA_W-1:0] alu_data,
        input logic              ls_en,
        input tag_t              ls_tag,
        input logic [DATA_W-1:0] ls_data
    );
        operand_t r;
        r = cur;
        if (cur.tag != TAG_FREE) begin
            if (alu_en && (alu_tag == cur.tag)) begin
                r.val = alu_data;
                r.tag = TAG_FREE;
            end else if (ls_en && (ls_tag == cur.tag)) begin
                r.val = ls_data;
                r.tag = TAG_FREE;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder shared by the ALU and LS reservation stations.
module rs_pick #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last hit, the lowest set bit, wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: 16 entries indexed by destination tag root,
// CDB wakeup on both buses, oldest-free-of-order lowest-index issue.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ALUen,
    input  op_t                  ALUop,
    input  logic [DATA_W-1:0]    ALUoperandO,
    input  logic [DATA_W-1:0]    ALUoperandT,
    input  tag_t                 ALUtagO,
    input  tag_t                 ALUtagT,
    input  tag_t                 ALUtagW,
    input  logic [NAME_W-1:0]    ALUnameW,
    input  logic [DATA_W-1:0]    ALUaddr,
    input  logic                 ALUcdbEn,
    input  tag_t                 ALUcdbTag,
    input  logic [DATA_W-1:0]    ALUcdbData,
    input  logic                 LScdbEn,
    input  tag_t                 LScdbTag,
    input  logic [DATA_W-1:0]    LScdbData,
    output logic [RS_SIZE-1:0]   ALUfreeStatus,
    output logic                 EXen,
    output op_t                  EXop,
    output logic [DATA_W-1:0]    EXoperandO,
    output logic [DATA_W-1:0]    EXoperandT,
    output tag_t                 EXtagW,
    output logic [NAME_W-1:0]    EXnameW,
    output logic [DATA_W-1:0]    EXaddr
);

    logic [RS_SIZE-1:0] valid;
    entry_t             ent [RS_SIZE];
    logic [RS_SIZE-1:0] ready;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   disp_idx;
    logic               disp_ok;
    operand_t           disp_o;
    operand_t           disp_t;

    assign disp_idx = ALUtagW[IDX_W-1:0];
    // A dispatch into an occupied slot is dropped; the slot keeps its contents.
    assign disp_ok  = ALUen && !valid[disp_idx];

    // Incoming operands see this cycle's broadcasts so no wakeup is lost.
    assign disp_o = snoop(operand_t'{val: ALUoperandO, tag: ALUtagO},
                          ALUcdbEn, ALUcdbTag, ALUcdbData, LScdbEn, LScdbTag, LScdbData);
    assign disp_t = snoop(operand_t'{val: ALUoperandT, tag: ALUtagT},
                          ALUcdbEn, ALUcdbTag, ALUcdbData, LScdbEn, LScdbTag, LScdbData);

    // Readiness looks only at registered state, giving one edge of latency.
    always_comb begin
        ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid[i] && (ent[i].opo.tag == TAG_FREE) && (ent[i].opt.tag == TAG_FREE);
        end
    end

    rs_pick #(
        .N     (RS_SIZE),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (ready),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Free mask hides the slot being dispatched this cycle from the allocator.
    always_comb begin
        ALUfreeStatus = ~valid;
        if (ALUen) begin
            ALUfreeStatus[disp_idx] = 1'b0;
        end
    end

    // Entry occupancy and the registered issue port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid      <= '0;
            EXen       <= 1'b0;
            EXop       <= '0;
            EXoperandO <= '0;
            EXoperandT <= '0;
            EXtagW     <= TAG_FREE;
            EXnameW    <= '0;
            EXaddr     <= '0;
        end else begin
            EXen <= pick_found;
            if (pick_found) begin
                EXop            <= ent[pick_idx].op;
                EXoperandO      <= ent[pick_idx].opo.val;
                EXoperandT      <= ent[pick_idx].opt.val;
                EXtagW          <= ent[pick_idx].tagw;
                EXnameW         <= ent[pick_idx].namew;
                EXaddr          <= ent[pick_idx].addr;
                valid[pick_idx] <= 1'b0;
            end
            // Issued slot was valid, so an accepted dispatch never targets it.
            if (disp_ok) begin
                valid[disp_idx] <= 1'b1;
            end
        end
    end

    // Entry payload: dispatch write or per-operand CDB capture; no reset needed
    // because readiness is qualified by valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (disp_ok && (disp_idx == IDX_W'(i))) begin
                ent[i] <= '{op: ALUop, opo: disp_o, opt: disp_t,
                            tagw: ALUtagW, namew: ALUnameW, addr: ALUaddr};
            end else begin
                ent[i].opo <= snoop(ent[i].opo, ALUcdbEn, ALUcdbTag, ALUcdbData,
                                    LScdbEn, LScdbTag, LScdbData);
                ent[i].opt <= snoop(ent[i].opt, ALUcdbEn, ALUcdbTag, ALUcdbData,
                                    LScdbEn, LScdbTag, LScdbData);
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed and randomized bench for alu_rs against a slot-array reference model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk;
    logic        rst;
    logic        ALUen;
    logic [3:0]  ALUop;
    logic [31:0] ALUoperandO, ALUoperandT;
    logic [5:0]  ALUtagO, ALUtagT, ALUtagW;
    logic [4:0]  ALUnameW;
    logic [31:0] ALUaddr;
    logic        ALUcdbEn;
    logic [5:0]  ALUcdbTag;
    logic [31:0] ALUcdbData;
    logic        LScdbEn;
    logic [5:0]  LScdbTag;
    logic [31:0] LScdbData;
    logic [15:0] ALUfreeStatus;
    logic        EXen;
    logic [3:0]  EXop;
    logic [31:0] EXoperandO, EXoperandT;
    logic [5:0]  EXtagW;
    logic [4:0]  EXnameW;
    logic [31:0] EXaddr;

    alu_rs dut (
        .clk(clk), .rst(rst),
        .ALUen(ALUen), .ALUop(ALUop), .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT),
        .ALUtagO(ALUtagO), .ALUtagT(ALUtagT), .ALUtagW(ALUtagW), .ALUnameW(ALUnameW),
        .ALUaddr(ALUaddr),
        .ALUcdbEn(ALUcdbEn), .ALUcdbTag(ALUcdbTag), .ALUcdbData(ALUcdbData),
        .LScdbEn(LScdbEn), .LScdbTag(LScdbTag), .LScdbData(LScdbData),
        .ALUfreeStatus(ALUfreeStatus),
        .EXen(EXen), .EXop(EXop), .EXoperandO(EXoperandO), .EXoperandT(EXoperandT),
        .EXtagW(EXtagW), .EXnameW(EXnameW), .EXaddr(EXaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per slot plus the expected issue port.
    bit          m_vld [16];
    logic [3:0]  m_op  [16];
    logic [31:0] m_vo  [16];
    logic [31:0] m_vt  [16];
    logic [5:0]  m_to  [16];
    logic [5:0]  m_tt  [16];
    logic [5:0]  m_tw  [16];
    logic [4:0]  m_nw  [16];
    logic [31:0] m_ad  [16];
    logic        e_en;
    logic [3:0]  e_op;
    logic [31:0] e_o, e_t, e_ad;
    logic [5:0]  e_tw;
    logic [4:0]  e_nw;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
        e_en = 1'b0; e_op = '0; e_o = '0; e_t = '0; e_ad = '0; e_nw = '0;
        e_tw = TAG_FREE;
    endtask

    // An operand waiting on a producer takes the data of whichever bus names
    // that producer this cycle, ALU bus first.
    task automatic resolve(input logic [5:0] tin, input logic [31:0] vin,
                           output logic [5:0] tout, output logic [31:0] vout);
        tout = tin;
        vout = vin;
        if (tin != TAG_FREE) begin
            if (ALUcdbEn && ALUcdbTag == tin) begin
                tout = TAG_FREE; vout = ALUcdbData;
            end else if (LScdbEn && LScdbTag == tin) begin
                tout = TAG_FREE; vout = LScdbData;
            end
        end
    endtask

    function automatic logic [15:0] model_free();
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = !m_vld[i] && !(ALUen && ALUtagW[3:0] == 4'(i));
        return r;
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int   pick;
        int   d;
        bit   take;
        pick = -1;
        d    = int'(ALUtagW[3:0]);
        take = ALUen && !m_vld[d];
        for (int i = 0; i < 16; i++)
            if (pick < 0 && m_vld[i] && m_to[i] == TAG_FREE && m_tt[i] == TAG_FREE) pick = i;
        if (pick >= 0) begin
            e_en = 1'b1; e_op = m_op[pick]; e_o = m_vo[pick]; e_t = m_vt[pick];
            e_tw = m_tw[pick]; e_nw = m_nw[pick]; e_ad = m_ad[pick];
            m_vld[pick] = 1'b0;
        end else begin
            e_en = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m_vld[i]) begin
                resolve(m_to[i], m_vo[i], m_to[i], m_vo[i]);
                resolve(m_tt[i], m_vt[i], m_tt[i], m_vt[i]);
            end
        end
        if (take) begin
            resolve(ALUtagO, ALUoperandO, m_to[d], m_vo[d]);
            resolve(ALUtagT, ALUoperandT, m_tt[d], m_vt[d]);
            m_op[d] = ALUop; m_tw[d] = ALUtagW; m_nw[d] = ALUnameW; m_ad[d] = ALUaddr;
            m_vld[d] = 1'b1;
        end
    endtask

    task automatic check_ex();
        chk("EXen", EXen, e_en);
        chk("EXop", EXop, e_op);
        chk("EXoperandO", EXoperandO, e_o);
        chk("EXoperandT", EXoperandT, e_t);
        chk("EXtagW", EXtagW, e_tw);
        chk("EXnameW", EXnameW, e_nw);
        chk("EXaddr", EXaddr, e_ad);
    endtask

    task automatic tick();
        #1;
        chk("freeStatus", ALUfreeStatus, model_free());
        model_step();
        @(posedge clk);
        #1;
        check_ex();
    endtask

    task automatic clr();
        ALUen = 1'b0; ALUcdbEn = 1'b0; LScdbEn = 1'b0;
    endtask

    task automatic disp(input logic [5:0] tw, input logic [5:0] to, input logic [5:0] tt,
                        input logic [31:0] vo, input logic [31:0] vt);
        ALUen = 1'b1; ALUtagW = tw; ALUtagO = to; ALUtagT = tt;
        ALUoperandO = vo; ALUoperandT = vt;
        ALUop = 4'($urandom); ALUnameW = 5'($urandom); ALUaddr = $urandom;
    endtask

    function automatic logic [5:0] rand_tag();
        logic [5:0] t;
        if ($urandom_range(0, 2) == 0) t = TAG_FREE;
        else t = {1'b0, ($urandom_range(0, 1) == 1) ? PREFIX_LS : PREFIX_ALU, 4'($urandom_range(0, 7))};
        return t;
    endfunction

    initial begin
        rst = 1'b0;
        ALUen = 0; ALUop = 0; ALUoperandO = 0; ALUoperandT = 0;
        ALUtagO = 0; ALUtagT = 0; ALUtagW = 0; ALUnameW = 0; ALUaddr = 0;
        ALUcdbEn = 0; ALUcdbTag = 0; ALUcdbData = 0;
        LScdbEn = 0; LScdbTag = 0; LScdbData = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_free", ALUfreeStatus, 16'hFFFF);
        check_ex();
        @(negedge clk);
        rst = 1'b1;

        // Ready-at-dispatch entry 3 issues one edge later, slot frees after
        disp(6'h03, TAG_FREE, TAG_FREE, 32'd5, 32'd7);
        tick(); clr();
        chk("s1_no_early", EXen, 1'b0);
        tick();
        chk("s1_en", EXen, 1'b1);
        chk("s1_o", EXoperandO, 32'd5);
        chk("s1_t", EXoperandT, 32'd7);
        chk("s1_free3", ALUfreeStatus[3], 1'b1);

        // Wait on LS entry 2, wake via LS bus
        disp(6'h02, 6'h12, TAG_FREE, 32'h111, 32'h222);
        tick(); clr();
        tick(); tick();
        chk("s2_blocked", EXen, 1'b0);
        LScdbEn = 1'b1; LScdbTag = 6'h12; LScdbData = 32'hDEAD;
        tick(); clr();
        chk("s2_wake_edge", EXen, 1'b0);
        tick();
        chk("s2_en", EXen, 1'b1);
        chk("s2_o", EXoperandO, 32'hDEAD);

        // Same-cycle dispatch and ALU broadcast
        disp(6'h07, TAG_FREE, 6'h05, 32'h33, 32'h0);
        ALUcdbEn = 1'b1; ALUcdbTag = 6'h05; ALUcdbData = 32'd9;
        tick(); clr();
        tick();
        chk("s3_en", EXen, 1'b1);
        chk("s3_t", EXoperandT, 32'd9);
        chk("s3_tw", EXtagW, 6'h07);

        // Both buses carry the same tag: ALU bus data wins
        disp(6'h0C, 6'h0A, TAG_FREE, 32'h0, 32'h1);
        ALUcdbEn = 1'b1; ALUcdbTag = 6'h0A; ALUcdbData = 32'hA1A1;
        LScdbEn = 1'b1; LScdbTag = 6'h0A; LScdbData = 32'hB2B2;
        tick(); clr();
        tick();
        chk("prio_o", EXoperandO, 32'hA1A1);

        // Entries 1 and 6 become ready together; lower index first
        disp(6'h06, 6'h13, TAG_FREE, 32'h0, 32'h66);
        tick();
        disp(6'h01, 6'h13, TAG_FREE, 32'h0, 32'h11);
        tick(); clr();
        LScdbEn = 1'b1; LScdbTag = 6'h13; LScdbData = 32'hABC;
        tick(); clr();
        tick();
        chk("s4_first", EXtagW, 6'h01);
        chk("s4_first_o", EXoperandO, 32'hABC);
        tick();
        chk("s4_second", EXtagW, 6'h06);
        chk("s4_second_en", EXen, 1'b1);

        // In-flight dispatch hides its slot; redispatch to a valid slot is dropped
        disp(6'h04, 6'h14, TAG_FREE, 32'h44, 32'h4444);
        #1;
        chk("s5_free4_now", ALUfreeStatus[4], 1'b0);
        tick(); clr();
        disp(6'h04, TAG_FREE, TAG_FREE, 32'h99, 32'h999);
        tick(); clr();
        tick();
        chk("s5_ignored", EXen, 1'b0);
        ALUcdbEn = 1'b1; ALUcdbTag = 6'h14; ALUcdbData = 32'h4545;
        tick(); clr();
        tick();
        chk("s5_o", EXoperandO, 32'h4545);
        chk("s5_t", EXoperandT, 32'h4444);

        // Asynchronous reset with three entries parked and an issue in flight
        disp(6'h08, 6'h1F, TAG_FREE, 32'h8, 32'h8); tick();
        disp(6'h09, 6'h1F, TAG_FREE, 32'h9, 32'h9); tick();
        disp(6'h0A, TAG_FREE, 6'h1F, 32'hA, 32'hA); tick();
        disp(6'h0B, TAG_FREE, TAG_FREE, 32'hB, 32'hB); tick(); clr();
        tick();
        chk("s6_pre_en", EXen, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("s6_en", EXen, 1'b0);
        chk("s6_free", ALUfreeStatus, 16'hFFFF);
        chk("s6_tw", EXtagW, TAG_FREE);
        chk("s6_o", EXoperandO, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            ALUen = ($urandom_range(0, 1) == 1);
            ALUtagW = {2'b00, 4'($urandom)};
            ALUtagO = rand_tag(); ALUtagT = rand_tag();
            ALUoperandO = $urandom; ALUoperandT = $urandom;
            ALUop = 4'($urandom); ALUnameW = 5'($urandom); ALUaddr = $urandom;
            ALUcdbEn = ($urandom_range(0, 1) == 1);
            ALUcdbTag = rand_tag(); ALUcdbData = $urandom;
            LScdbEn = ($urandom_range(0, 1) == 1);
            LScdbTag = rand_tag(); LScdbData = $urandom;
            tick();
        end
        clr();
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
